seq_muldiv: RTL

Iterative multiply/divide unit with a go/done handshake and its own operand datapath. It is parametrised in operand width. It supports four operations: unsigned multiply, signed multiply, unsigned divide and signed divide. It replaces fixed-width single-function shift-add controllers. It sits beside the ALU and serves any master that can hold off while `busy` is high.

---
 rtl/seq_muldiv_if.sv | 16 +
 rtl/seq_muldiv.sv | 85 ++++++++
 2 files changed

// File: rtl/seq_muldiv_if.sv
// seq_muldiv_if: go/done handshake plus operand and result bus for seq_muldiv
//   master drives go/op/a/b and observes busy/done/result_hi/result_lo/div_by_zero
//   slave (the unit) is the mirror image
interface seq_muldiv_if #(parameter int WIDTH = 8);
  logic go;
  logic [1:0] op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic busy;
  logic done;
  logic [WIDTH-1:0] result_hi;
  logic [WIDTH-1:0] result_lo;
  logic div_by_zero;
  modport master(output go, op, a, b, input busy, done, result_hi, result_lo, div_by_zero);
  modport slave(input go, op, a, b, output busy, done, result_hi, result_lo, div_by_zero);
endinterface

// File: rtl/seq_muldiv.sv
// seq_muldiv: iterative unsigned/signed multiply and divide, one bit per cycle
//   clk, reset (async, active-high), bus: slave side of seq_muldiv_if
//   op 00 umul, 01 smul (Booth), 10 udiv, 11 sdiv; results hi=product hi/remainder, lo=product lo/quotient
module seq_muldiv #(parameter int WIDTH = 8) (
  input logic clk,
  input logic reset,
  seq_muldiv_if.slave bus
);
  localparam int W = WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [1:0] r_op;
  logic r_guard, r_neg_q, r_neg_r, r_dbz;
  logic [2*W-1:0] r_acc, w_acc;
  logic [W-1:0] r_b, r_hi, r_lo, w_a_in, w_b_in, w_hi_f, w_lo_f;
  logic [W:0] w_hi_x, w_b_x, w_mul, w_rem, w_diff;
  logic w_zero, w_last;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_zero = bus.op[1] && bus.b == '0;
    w_last = r_cnt == CW'(1);
    w_next = r_state == IDLE ? (bus.go ? (w_zero ? DONE : RUN) : IDLE)
           : r_state == RUN ? (w_last ? DONE : RUN) : IDLE;
  end
  // Accumulator upper half is carried one bit wider so the Booth add/sub of the
  // most negative multiplicand and the unsigned carry-out are never lost.
  always_comb begin
    w_a_in = bus.op == 2'b11 && bus.a[W-1] ? -bus.a : bus.a;
    w_b_in = bus.op == 2'b11 && bus.b[W-1] ? -bus.b : bus.b;
    w_hi_x = {r_op[0] & r_acc[2*W-1], r_acc[2*W-1:W]};
    w_b_x = {r_op[0] & r_b[W-1], r_b};
    w_mul = r_op[0] ? (r_acc[0] == r_guard ? w_hi_x : r_acc[0] ? w_hi_x - w_b_x : w_hi_x + w_b_x)
                    : (r_acc[0] ? w_hi_x + w_b_x : w_hi_x);
    w_rem = {r_acc[2*W-1:W], r_acc[W-1]};
    w_diff = w_rem - {1'b0, r_b};
    w_acc = r_op[1] ? {w_diff[W] ? w_rem[W-1:0] : w_diff[W-1:0], r_acc[W-2:0], ~w_diff[W]}
                    : {w_mul, r_acc[W-1:1]};
    w_lo_f = r_op == 2'b11 && r_neg_q ? -w_acc[W-1:0] : w_acc[W-1:0];
    w_hi_f = r_op == 2'b11 && r_neg_r ? -w_acc[2*W-1:W] : w_acc[2*W-1:W];
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_cnt <= '0;
      r_op <= '0;
      r_acc <= '0;
      r_b <= '0;
      r_guard <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dbz <= 1'b0;
      r_hi <= '0;
      r_lo <= '0;
    end else if (r_state == IDLE && bus.go) begin
      r_op <= bus.op;
      r_dbz <= w_zero;
      if (w_zero) begin
        r_hi <= bus.a;
        r_lo <= '1;
      end else begin
        r_cnt <= CW'(W);
        r_acc <= {{W{1'b0}}, w_a_in};
        r_b <= w_b_in;
        r_guard <= 1'b0;
        r_neg_q <= bus.a[W-1] ^ bus.b[W-1];
        r_neg_r <= bus.a[W-1];
      end
    end else if (r_state == RUN) begin
      r_acc <= w_acc;
      r_guard <= r_acc[0];
      r_cnt <= r_cnt - 1'b1;
      if (w_last) begin
        r_hi <= w_hi_f;
        r_lo <= w_lo_f;
      end
    end
  assign bus.busy = r_state != IDLE;
  assign bus.done = r_state == DONE;
  assign bus.result_hi = r_hi;
  assign bus.result_lo = r_lo;
  assign bus.div_by_zero = r_dbz;
endmodule
